// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit: operation encoding and
// the occupancy states of the output skid buffer.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Combinational bitwise logic function over WIDTH bits; the zero flag is
// derived from the result it produces.
module logic_unit_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] s_o,
    output logic             zero_o
);

    always_comb begin
        s_o = '0;
        unique case (op_i)
            OP_NOT:  s_o = ~a_i;
            OP_AND:  s_o = a_i & b_i;
            OP_OR:   s_o = a_i | b_i;
            OP_XOR:  s_o = a_i ^ b_i;
            OP_NAND: s_o = ~(a_i & b_i);
            OP_NOR:  s_o = ~(a_i | b_i);
            OP_XNOR: s_o = ~(a_i ^ b_i);
            OP_PASS: s_o = a_i;
        endcase
    end

    assign zero_o = ~|s_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides and a
// two-entry skid buffer so backpressure never costs throughput.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter bit ZERO_FLAG_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  op_t               op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  s_o,
    output logic              zero_o,
    output skid_state_t       state_o
);

    // Handshake rule on both ports: a transfer happens exactly at a rising
    // edge where valid and ready are both high; the sender holds its data
    // stable while valid is high and ready is low.

    skid_state_t      state;
    skid_state_t      next_state;

    logic [WIDTH-1:0] f_s;
    logic             f_zero;
    logic             cap_zero;

    logic [WIDTH-1:0] main_s;
    logic             main_zero;
    logic [WIDTH-1:0] skid_s;
    logic             skid_zero;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    logic_unit_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a_i   (a_i),
        .b_i   (b_i),
        .op_i  (op_i),
        .s_o   (f_s),
        .zero_o(f_zero)
    );

    assign cap_zero = ZERO_FLAG_EN ? f_zero : 1'b0;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: begin
                if (in_xfer) next_state = ONE;
            end
            ONE: begin
                if (in_xfer && !out_xfer)      next_state = FULL;
                else if (!in_xfer && out_xfer) next_state = EMPTY;
            end
            FULL: begin
                if (out_xfer) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        valid_o        = (state != EMPTY);
        ready_o        = (state != FULL) && !rst_i;
        state_o        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: load_main_in = in_xfer;
            ONE: begin
                load_main_in = in_xfer && out_xfer;
                load_skid    = in_xfer && !out_xfer;
            end
            FULL:    load_main_skid = out_xfer;
            default: ;
        endcase
    end

    // zero is captured alongside the result so it never depends on s_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_s    <= '0;
            main_zero <= 1'b0;
            skid_s    <= '0;
            skid_zero <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_s    <= f_s;
                main_zero <= cap_zero;
            end else if (load_main_skid) begin
                main_s    <= skid_s;
                main_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_s    <= f_s;
                skid_zero <= cap_zero;
            end
        end
    end

    assign s_o    = main_s;
    assign zero_o = main_zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model checked every cycle,
// directed literal cases, backpressure, async reset and an 8-bit instance.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         valid_i;
    logic         ready_o;
    op_t          op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] s_o;
    logic         zero_o;
    skid_state_t  state_o;

    logic         v8_valid_i;
    logic         v8_ready_o;
    op_t          v8_op_i;
    logic [7:0]   v8_a_i;
    logic [7:0]   v8_b_i;
    logic         v8_valid_o;
    logic         v8_ready_i;
    logic [7:0]   v8_s_o;
    logic         v8_zero_o;
    skid_state_t  v8_state_o;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    logic         last_in = 1'b0;

    logic_unit_pipe #(.WIDTH(W), .ZERO_FLAG_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o),
        .ready_i(ready_i), .s_o(s_o), .zero_o(zero_o), .state_o(state_o)
    );

    logic_unit_pipe #(.WIDTH(8), .ZERO_FLAG_EN(1'b1)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8_valid_i), .ready_o(v8_ready_o),
        .op_i(v8_op_i), .a_i(v8_a_i), .b_i(v8_b_i), .valid_o(v8_valid_o),
        .ready_i(v8_ready_i), .s_o(v8_s_o), .zero_o(v8_zero_o), .state_o(v8_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] f(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // ---------------- scoreboard / compare process ----------------
    // Model: an in-order queue holding at most two results.
    always @(negedge clk) begin
        logic exp_valid, exp_ready, do_in, do_out;
        skid_state_t exp_state;
        if (rst) begin
            exp_q.delete();
            last_in = 1'b0;
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_s", s_o, 32'd0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = (exp_q.size() < 2);
            exp_state = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : FULL;
            chk("valid_o", 32'(valid_o), 32'(exp_valid));
            chk("ready_o", 32'(ready_o), 32'(exp_ready));
            chk("state", 32'(state_o), 32'(exp_state));
            if (exp_valid) begin
                chk("s_o", s_o, exp_q[0]);
                chk("zero_o", 32'(zero_o), 32'(exp_q[0] == '0));
            end
            do_out = exp_valid && ready_i;
            do_in  = valid_i && exp_ready;
            if (do_out) begin
                out_log.push_back(s_o);
                void'(exp_q.pop_front());
            end
            if (do_in) exp_q.push_back(f(op_i, a_i, b_i));
            last_in = do_in;
        end
    end

    // ---------------- driver tasks (call at posedge+1) ----------------
    task automatic send(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (last_in) begin
                valid_i = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd1, 32'd0);
        valid_i = 1'b0;
    endtask

    task automatic send_expect(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_s, input logic exp_z);
        send(op, a, b);
        @(negedge clk);
        chk("lit_valid", 32'(valid_o), 32'd1);
        chk("lit_s", s_o, exp_s);
        chk("lit_zero", 32'(zero_o), 32'(exp_z));
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_i = OP_NOT; a_i = '0; b_i = '0;
        v8_valid_i = 1'b0; v8_ready_i = 1'b1; v8_op_i = OP_NOT; v8_a_i = '0; v8_b_i = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_s", s_o, 32'd0);
        chk("reset_zero", 32'(zero_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model against hand-computed values.
        chk("model_and", f(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00), 32'hF000F000);
        chk("model_xnor", f(OP_XNOR, 32'hF0F0F0F0, 32'hFF00FF00), 32'hF00FF00F);

        // NOT on three patterns
        send_expect(OP_NOT, 32'h00000000, 32'h0, 32'hFFFFFFFF, 1'b0);
        send_expect(OP_NOT, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1'b1);
        send_expect(OP_NOT, 32'h12345678, 32'h0, 32'hEDCBA987, 1'b0);

        // All eight ops on one operand pair
        send_expect(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        send_expect(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        send_expect(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        send_expect(OP_NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0);
        send_expect(OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0);
        send_expect(OP_XNOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0);
        send_expect(OP_PASS, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0);
        send_expect(OP_NOT,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0);

        // Backpressure: three back-to-back ops while downstream stalls
        base = out_log.size();
        ready_i = 1'b0;
        valid_i = 1'b1; op_i = OP_AND; a_i = 32'hF0F0F0F0; b_i = 32'hFF00FF00;
        @(posedge clk); #1;
        op_i = OP_OR; a_i = 32'h12345678; b_i = 32'h0F0F0F0F;
        @(posedge clk); #1;
        op_i = OP_XOR; a_i = 32'hAAAAAAAA; b_i = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(ready_o), 32'd0);
            chk("bp_hold", s_o, 32'hF000F000);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        begin : wait_third
            for (int n = 0; n < 20; n++) begin
                @(posedge clk); #1;
                if (last_in) disable wait_third;
            end
            chk("bp_timeout", 32'd1, 32'd0);
        end
        valid_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("bp_count", 32'(out_log.size() - base), 32'd3);
        if (out_log.size() - base == 3) begin
            chk("bp_r1", out_log[base],     32'hF000F000);
            chk("bp_r2", out_log[base + 1], 32'h1F3F5F7F);
            chk("bp_r3", out_log[base + 2], 32'hFFFFFFFF);
        end

        // Continuous stream with ready_i high: one result per cycle
        base = out_log.size();
        for (int i = 0; i < 10; i++)
            send(op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        repeat (2) @(posedge clk); #1;
        chk("stream_count", 32'(out_log.size() - base), 32'd10);

        // Asynchronous reset while FULL
        ready_i = 1'b0;
        send(OP_PASS, 32'h11111111, 32'h0);
        send(OP_PASS, 32'h22222222, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", 32'(valid_o), 32'd0);
        chk("areset_s", s_o, 32'd0);
        chk("areset_ready", 32'(ready_o), 32'd0);
        chk("areset_state", 32'(state_o), 32'(EMPTY));
        @(posedge clk); #1 rst = 1'b0;
        ready_i = 1'b1;
        base = out_log.size();
        send(OP_NOT, 32'h0000FFFF, 32'h0);
        repeat (3) @(posedge clk); #1;
        chk("areset_alone", 32'(out_log.size() - base), 32'd1);
        if (out_log.size() - base == 1) chk("areset_val", out_log[base], 32'hFFFF0000);

        // Randomized traffic, valid held until accepted
        for (int c = 0; c < 400; c++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if (!valid_i || last_in) begin
                valid_i = ($urandom_range(0, 3) != 0);
                op_i = op_t'($urandom_range(0, 7));
                a_i = ($urandom_range(0, 7) == 0) ? b_i : W'($urandom);
                b_i = W'($urandom);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("drain_valid", 32'(valid_o), 32'd0);

        // 8-bit instance
        v8_valid_i = 1'b1; v8_op_i = OP_NOT; v8_a_i = 8'h5A;
        @(posedge clk); #1 v8_valid_i = 1'b0;
        @(negedge clk);
        chk("w8_not", 32'(v8_s_o), 32'h000000A5);
        chk("w8_not_zero", 32'(v8_zero_o), 32'd0);
        chk("w8_state", 32'(v8_state_o), 32'(ONE));
        @(posedge clk); #1;
        v8_valid_i = 1'b1; v8_op_i = OP_XOR; v8_a_i = 8'h5A; v8_b_i = 8'h5A;
        @(posedge clk); #1 v8_valid_i = 1'b0;
        @(negedge clk);
        chk("w8_xor", 32'(v8_s_o), 32'h00000000);
        chk("w8_xor_zero", 32'(v8_zero_o), 32'd1);
        chk("w8_valid", 32'(v8_valid_o), 32'd1);
        chk("w8_ready", 32'(v8_ready_o), 32'd1);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit. Successor to the single-operand configurable NOT gate. Adds a width parameter, a 3-bit operation select, a second operand, a zero flag, and valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput under backpressure. Sits between the decode/operand stage and writeback as the logic sub-path of the ALU.

Parameters:
WIDTH, 32, operand and result width in bits (>= 1)
ZERO_FLAG_EN, 1, 1 = zero_o computed; 0 = zero_o tied 0

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  upstream has a valid op/operands
ready_o  out  1  unit can accept this cycle
op_i  in  3  operation select (op_t)
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B (ignored for NOT/PASS)
valid_o  out  1  s_o/zero_o hold a valid result
ready_i  in  1  downstream accepts result
s_o  out  WIDTH  result
zero_o  out  1  result == 0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Handshakes: input transfer when valid_i && ready_o at a rising edge. Output transfer when valid_o && ready_i at a rising edge.
- Operations, all bitwise over WIDTH:
  - NOT = ~a
  - AND = a & b
  - OR = a | b
  - XOR = a ^ b
  - NAND = ~(a & b)
  - NOR = ~(a | b)
  - XNOR = ~(a ^ b)
  - PASS = a
- Latency: result visible on s_o the cycle after input transfer. Throughput 1 result/cycle while ready_i = 1.
- Storage:
  - main register {s, zero} drives the outputs.
  - skid register {s, zero} catches one extra result.
- FSM states: EMPTY, ONE, FULL.
  - EMPTY:
    - in-xfer -> ONE, main <= f(in).
  - ONE:
    - in & out -> ONE, main <= f(in).
    - in & !out -> FULL, skid <= f(in).
    - !in & out -> EMPTY.
    - neither -> stay.
  - FULL (no input accepted):
    - out -> ONE, main <= skid.
    - else stay.
- Outputs:
  - valid_o = (state != EMPTY).
  - ready_o = (state != FULL) && !rst_i.
  - s_o = main.s; zero_o = main.zero.
  - All are registered or state-decoded; no combinational path from valid_i, op_i, a_i or b_i to any output.
- Stability: while valid_o = 1 and ready_i = 0, s_o and zero_o stay constant.
- Ordering: results leave strictly in acceptance order; never dropped, never duplicated.
- Reset, asserted asynchronously at any time including mid-transfer or FULL:
  - state = EMPTY; main and skid = 0.
  - valid_o = 0, s_o = 0, zero_o = 0, ready_o = 0 while rst_i = 1.
  - Pending results are discarded.
  - Cycle after deassertion: ready_o = 1.
- Illegal op values: none; all 8 encodings are defined.
- zero_o is computed from the result at capture time, not from s_o combinationally.
- WIDTH = 1 must work; no width-dependent constants other than WIDTH.

Decomposition:
- Package logic_unit_pkg:
  - typedef enum logic [2:0] op_t: OP_NOT=0, OP_AND=1, OP_OR=2, OP_XOR=3, OP_NAND=4, OP_NOR=5, OP_XNOR=6, OP_PASS=7.
  - typedef enum logic [1:0] skid_state_t: EMPTY, ONE, FULL.
- Sub-module logic_unit_comb, combinational:
  - Parameter WIDTH.
  - Inputs a_i, b_i, op_i.
  - Outputs s_o, zero_o.
  - Direct generalisation of the configurable NOT gate.
- logic_unit_pipe instantiates logic_unit_comb and holds the FSM, main and skid registers.

Test Plan:
1. WIDTH=32, ready_i=1; OP_NOT with a=0x00000000, then 0xFFFFFFFF, then 0x12345678 -> s_o = 0xFFFFFFFF, 0x00000000 (zero_o=1), 0xEDCBA987, each one cycle after acceptance.
2. a=0xF0F0F0F0, b=0xFF00FF00 through all 8 ops -> AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NAND 0x0FFF0FFF, NOR 0x000F000F, XNOR 0xF00FF00F, PASS 0xF0F0F0F0, NOT 0x0F0F0F0F.
3. Backpressure: ready_i=0, offer 3 back-to-back ops -> first two accepted, ready_o=0 from the cycle after the second, s_o holds result 1. Raise ready_i -> results 1, 2, 3 in order, no loss or duplication.
4. Simultaneous in/out in ONE with ready_i=1 and continuous valid_i for 10 cycles -> one result per cycle, state stays ONE, ready_o stays 1.
5. Assert rst_i asynchronously (mid-cycle) while FULL -> valid_o, s_o and ready_o go 0 immediately. After release, ready_o=1 and the next accepted op emerges alone.
6. WIDTH=8 instance: OP_NOT a=0x5A -> 0xA5; OP_XOR a=0x5A, b=0x5A -> 0x00 with zero_o=1.
